// File: rtl/regbank_mp.sv
// regbank_mp: parametrised register bank with two combinational read ports,
// two synchronous write ports (port 2 wins on collision), an optional
// hardwired-zero register 0, optional write-to-read bypass and a per-register
// busy scoreboard used to track outstanding producers in a pipeline.
module regbank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write1,
  input  logic [ADDR_W-1:0] dr1,
  input  logic [DATA_W-1:0] wrdata1,
  input  logic              write2,
  input  logic [ADDR_W-1:0] dr2,
  input  logic [DATA_W-1:0] wrdata2,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_dr,
  output logic              busy1,
  output logic              busy2
);

  localparam int NREG      = 1 << ADDR_W;
  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Effective enables: anything aimed at a hardwired register 0 is dropped here,
  // so the storage and the bypass path never see it.
  logic we1_s;
  logic we2_s;
  logic rsv_s;

  assign we1_s = write1 & ~(ZERO_EN & (dr1 == {ADDR_W{1'b0}}));
  assign we2_s = write2 & ~(ZERO_EN & (dr2 == {ADDR_W{1'b0}}));
  assign rsv_s = rsv    & ~(ZERO_EN & (rsv_dr == {ADDR_W{1'b0}}));

  // Read mux for one port: zero register first, then bypass (port 2 over port 1),
  // then stored contents.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] sr,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (ZERO_EN && (sr == {ADDR_W{1'b0}})) begin
      val = {DATA_W{1'b0}};
    end else if (BYPASS_EN && we2_s && (dr2 == sr)) begin
      val = wrdata2;
    end else if (BYPASS_EN && we1_s && (dr1 == sr)) begin
      val = wrdata1;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Next-state of the array and scoreboard: port 2 overrides port 1 on the same
  // register, and a reservation overrides the busy clear from a same-cycle write.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = (we2_s && (dr2 == ADDR_W'(i))) ? wrdata2 :
                  (we1_s && (dr1 == ADDR_W'(i))) ? wrdata1 : regs_q[i];
      busy_d[i] = (rsv_s && (rsv_dr == ADDR_W'(i))) ? 1'b1 :
                  ((we1_s && (dr1 == ADDR_W'(i))) ||
                   (we2_s && (dr2 == ADDR_W'(i)))) ? 1'b0 : busy_q[i];
    end
  end

  // State registers with synchronous reset; reset discards same-cycle writes
  // and reservations.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      busy_q <= {NREG{1'b0}};
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Combinational read ports; busy reflects stored state only (never bypassed).
  always_comb begin
    rd_data1 = read_sel(sr1, regs_q[sr1]);
    rd_data2 = read_sel(sr2, regs_q[sr2]);
    if (ZERO_EN && (sr1 == {ADDR_W{1'b0}})) begin
      busy1 = 1'b0;
    end else begin
      busy1 = busy_q[sr1];
    end
    if (ZERO_EN && (sr2 == {ADDR_W{1'b0}})) begin
      busy2 = 1'b0;
    end else begin
      busy2 = busy_q[sr2];
    end
  end

endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: drives two regbank_mp instances in parallel, one with the
// defaults (ZERO_REG=1, BYPASS=1) and one with ZERO_REG=0, BYPASS=0, and checks
// both against a behavioural array model plus directed constant checks.
module tb_regbank_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        write1, write2, rsv;
  logic [4:0]  dr1, dr2, sr1, sr2, rsv_dr;
  logic [31:0] wrdata1, wrdata2;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        b1_a, b2_a, b1_b, b2_b;

  int n_vec  = 0;
  int n_fail = 0;

  // model: index 0 = instance a (zr=1,bp=1), index 1 = instance b (zr=0,bp=0)
  logic [31:0] mem [2][32];
  bit          bsy [2][32];

  always #5 clk = ~clk;

  regbank_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst),
    .write1(write1), .dr1(dr1), .wrdata1(wrdata1),
    .write2(write2), .dr2(dr2), .wrdata2(wrdata2),
    .sr1(sr1), .sr2(sr2), .rd_data1(rd1_a), .rd_data2(rd2_a),
    .rsv(rsv), .rsv_dr(rsv_dr), .busy1(b1_a), .busy2(b2_a)
  );

  regbank_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .write1(write1), .dr1(dr1), .wrdata1(wrdata1),
    .write2(write2), .dr2(dr2), .wrdata2(wrdata2),
    .sr1(sr1), .sr2(sr2), .rd_data1(rd1_b), .rd_data2(rd2_b),
    .rsv(rsv), .rsv_dr(rsv_dr), .busy1(b1_b), .busy2(b2_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit zr_of(input int k);
    return (k == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] sr);
    if (zr_of(k) && sr == 5'd0) return 32'd0;
    if (k == 0) begin
      if (write2 && dr2 == sr) return wrdata2;
      if (write1 && dr1 == sr) return wrdata1;
    end
    return mem[k][sr];
  endfunction

  function automatic logic exp_busy(input int k, input logic [4:0] sr);
    if (zr_of(k) && sr == 5'd0) return 1'b0;
    return bsy[k][sr];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin mem[k][r] = 32'd0; bsy[k][r] = 1'b0; end
      end else begin
        if (write1 && !(zr_of(k) && dr1 == 5'd0)) begin mem[k][dr1] = wrdata1; bsy[k][dr1] = 1'b0; end
        if (write2 && !(zr_of(k) && dr2 == 5'd0)) begin mem[k][dr2] = wrdata2; bsy[k][dr2] = 1'b0; end
        if (rsv && !(zr_of(k) && rsv_dr == 5'd0)) bsy[k][rsv_dr] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    check_val("a_rd1",  rd1_a, exp_rd(0, sr1));
    check_val("a_rd2",  rd2_a, exp_rd(0, sr2));
    check_val("a_bsy1", {31'd0, b1_a}, {31'd0, exp_busy(0, sr1)});
    check_val("a_bsy2", {31'd0, b2_a}, {31'd0, exp_busy(0, sr2)});
    check_val("b_rd1",  rd1_b, exp_rd(1, sr1));
    check_val("b_rd2",  rd2_b, exp_rd(1, sr2));
    check_val("b_bsy1", {31'd0, b1_b}, {31'd0, exp_busy(1, sr1)});
    check_val("b_bsy2", {31'd0, b2_b}, {31'd0, exp_busy(1, sr2)});
  endtask

  // Inputs are set just after a falling edge; check, clock, update model.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; write1 = 1'b0; write2 = 1'b0; rsv = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin mem[k][r] = 32'd0; bsy[k][r] = 1'b0; end
    idle();
    dr1 = 5'd0; dr2 = 5'd0; rsv_dr = 5'd0; sr1 = 5'd0; sr2 = 5'd0;
    wrdata1 = 32'd0; wrdata2 = 32'd0;
    @(negedge clk);

    // reset
    rst = 1'b1; tick(); idle();
    sr1 = 5'd17; sr2 = 5'd30; #1;
    check_val("rst_rd1", rd1_a, 32'd0); check_val("rst_rd2", rd2_b, 32'd0);
    check_val("rst_bsy", {31'd0, b1_b}, 32'd0);

    // fill
    for (int k = 0; k < 32; k++) begin
      write1 = 1'b1; dr1 = 5'(k); wrdata1 = 32'(20 * k); tick();
    end
    idle(); sr1 = 5'd7; sr2 = 5'd31; #1;
    check_val("fill7", rd1_a, 32'd140); check_val("fill31", rd2_a, 32'd620);
    sr1 = 5'd0; #1;
    check_val("zr_a0", rd1_a, 32'd0); check_val("zr_b0", rd1_b, 32'd0);
    write1 = 1'b1; dr1 = 5'd0; wrdata1 = 32'd5; tick(); idle(); #1;
    check_val("zr_a5", rd1_a, 32'd0); check_val("zr_b5", rd1_b, 32'd5);

    // dual write collision, then distinct destinations
    write1 = 1'b1; dr1 = 5'd9; wrdata1 = 32'h0000AAAA;
    write2 = 1'b1; dr2 = 5'd9; wrdata2 = 32'h00005555; tick(); idle();
    sr1 = 5'd9; #1;
    check_val("coll_a", rd1_a, 32'h00005555); check_val("coll_b", rd1_b, 32'h00005555);
    write1 = 1'b1; dr1 = 5'd3; wrdata1 = 32'h33;
    write2 = 1'b1; dr2 = 5'd4; wrdata2 = 32'h44; tick(); idle();
    sr1 = 5'd3; sr2 = 5'd4; #1;
    check_val("dist3", rd1_b, 32'h33); check_val("dist4", rd2_b, 32'h44);

    // bypass vs no bypass
    sr1 = 5'd12; write1 = 1'b1; dr1 = 5'd12; wrdata1 = 32'h1234; #1;
    check_val("byp_a", rd1_a, 32'h1234); check_val("nobyp_b", rd1_b, 32'd240);
    tick(); idle(); #1;
    check_val("post_b", rd1_b, 32'h1234);

    // scoreboard
    sr1 = 5'd6; rsv = 1'b1; rsv_dr = 5'd6; #1;
    check_val("rsv_same", {31'd0, b1_a}, 32'd0);
    tick(); idle(); #1;
    check_val("rsv_a", {31'd0, b1_a}, 32'd1); check_val("rsv_b", {31'd0, b1_b}, 32'd1);
    write2 = 1'b1; dr2 = 5'd6; wrdata2 = 32'h66; tick(); idle(); #1;
    check_val("clr_a", {31'd0, b1_a}, 32'd0);
    rsv = 1'b1; rsv_dr = 5'd6; write1 = 1'b1; dr1 = 5'd6; wrdata1 = 32'hBEEF;
    tick(); idle(); #1;
    check_val("rsvw_bsy", {31'd0, b1_a}, 32'd1); check_val("rsvw_dat", rd1_b, 32'hBEEF);

    // zero register
    sr1 = 5'd0; write1 = 1'b1; dr1 = 5'd0; wrdata1 = 32'hFFFF; rsv = 1'b1; rsv_dr = 5'd0; #1;
    check_val("z_byp", rd1_a, 32'd0);
    tick(); idle(); #1;
    check_val("z_rd", rd1_a, 32'd0); check_val("z_bsy", {31'd0, b1_a}, 32'd0);
    check_val("nz_rd", rd1_b, 32'hFFFF); check_val("nz_bsy", {31'd0, b1_b}, 32'd1);

    // reset mid-operation
    rsv = 1'b1; rsv_dr = 5'd2; tick();
    rsv_dr = 5'd3; tick(); idle();
    write1 = 1'b1; dr1 = 5'd2; wrdata1 = 32'd77; tick();
    rst = 1'b1; dr1 = 5'd5; wrdata1 = 32'd99; tick(); idle();
    sr1 = 5'd2; sr2 = 5'd5; #1;
    check_val("mrst2", rd1_a, 32'd0); check_val("mrst5", rd2_b, 32'd0);
    sr1 = 5'd3; #1;
    check_val("mrst_b3", {31'd0, b1_a}, 32'd0);

    // randomized traffic, biased towards a few registers for collisions
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      write1  = $urandom_range(0, 1);
      write2  = $urandom_range(0, 1);
      rsv     = ($urandom_range(0, 2) == 0);
      dr1     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      dr2     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rsv_dr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      sr1     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      sr2     = ($urandom_range(0, 3) == 0) ? sr1 : 5'($urandom);
      wrdata1 = $urandom;
      wrdata2 = $urandom;
      tick();
    end
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
# regbank_mp

Parametrised multi-port register bank, successor to the fixed 32x32 single-write regbank. Provides two combinational read ports, two synchronous write ports with deterministic collision priority, an optional hardwired-zero register, optional write-to-read bypass, and a per-register busy scoreboard for pipelined datapaths. It sits between decode (sources/reservations) and writeback (results) in the processor datapath.

## Interface

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NREG = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 always reads 0; writes and reservations to it are ignored
- BYPASS, 1, 1 = a read of a register being written this cycle returns the incoming write data

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- write1  in  1  write enable, port 1
- dr1  in  ADDR_W  destination register, port 1
- wrdata1  in  DATA_W  write data, port 1
- write2  in  1  write enable, port 2
- dr2  in  ADDR_W  destination register, port 2
- wrdata2  in  DATA_W  write data, port 2
- sr1, sr2  in  ADDR_W  source register selects
- rd_data1, rd_data2  out  DATA_W  read data for sr1, sr2 (combinational)
- rsv  in  1  reserve request: mark rsv_dr busy
- rsv_dr  in  ADDR_W  register to reserve
- busy1, busy2  out  1  stored busy bit of sr1, sr2 (combinational)

## Operation

- Storage: NREG x DATA_W register array plus NREG busy bits.
- Reset: rst high at a rising edge clears all registers to 0 and all busy bits to 0; writes and reservations in that cycle are discarded. Reset mid-sequence discards all pending reservations.
- Write: writeN high at a rising edge stores wrdataN into drN and clears busy[drN].
- Write collision: write1 and write2 both high with dr1 == dr2 -> wrdata2 stored (port 2 wins); busy cleared once.
- Reserve: rsv high at a rising edge sets busy[rsv_dr]. Reserve and write to the same register in the same cycle -> busy ends set (reservation is for the newer producer); data is still written.
- Read: rd_dataN = array[srN] combinationally. With BYPASS=1, if writeK is high and drK == srN (and not suppressed by ZERO_REG), rd_dataN = wrdataK, port 2 taking priority over port 1. With BYPASS=0, the new value is visible only after the edge.
- busyN = busy[srN] stored value; not bypassed by same-cycle writes or reservations.
- ZERO_REG=1: reads of register 0 return 0 and busy 0 regardless of bypass; writes/reservations to register 0 have no effect. ZERO_REG=0: register 0 is an ordinary register.
- sr1 == sr2 is legal; both ports return identical data.

## Timing

- Write latency: 1 edge to array; 0 cycles to read ports when BYPASS=1.
- Reservation latency: busy visible on busyN the cycle after the rsv edge.
- Read path purely combinational; no read enable, no read latency.
- Output values after reset: rd_data1/rd_data2 = 0, busy1/busy2 = 0 for any sr1/sr2.
- No handshake; every enabled write or reservation is accepted at its edge.

## Test plan

- Reset then fill: rst 1 cycle, then write1 reg k with 20*k for k=0..31 -> ZERO_REG=1: sr1=0 reads 0, sr1=7 reads 140, sr2=31 reads 620; ZERO_REG=0: sr1=0 reads 0 (written 0), reg 0 writable with 5 -> reads 5.
- Dual write collision: write1 dr1=9 wrdata1=0xAAAA, write2 dr2=9 wrdata2=0x5555 same edge -> sr1=9 reads 0x5555; distinct dr1=3/dr2=4 -> both stored.
- Bypass: BYPASS=1, sr1=12, write1 dr1=12 wrdata1=0x1234 -> rd_data1=0x1234 in the same cycle before the edge; BYPASS=0 -> old value until after edge.
- Scoreboard: rsv rsv_dr=6 -> busy1 (sr1=6) = 1 next cycle; write2 dr2=6 -> busy1 = 0 next cycle; simultaneous rsv and write to 6 -> busy1 = 1 and data updated.
- Zero register: ZERO_REG=1, write1 dr1=0 wrdata1=0xFFFF and rsv rsv_dr=0 -> rd_data1 = 0, busy1 = 0, also with bypass active.
- Reset mid-operation: reserve regs 2,3, write reg 2 = 77, assert rst together with write1 dr1=5 -> after edge all reads 0, busy 0, reg 5 = 0.
